// File: rtl/pix_unpacker_pkg.sv
// ---------------------------------------------------------------------------
// pix_unpacker_pkg
//   Shared definitions for the image-load front end: top-level mode codes,
//   default frame header bytes, the pixel type, the unpacker FSM encoding
//   and the helpers that turn 3 received bytes into two 12-bit pixels.
// ---------------------------------------------------------------------------
package pix_unpacker_pkg;

    // Top-level mode codes carried on state_i
    localparam logic [7:0] MODE_WAIT = 8'h01;
    localparam logic [7:0] MODE_RX   = 8'h02;
    localparam logic [7:0] MODE_DISP = 8'h03;

    // Default frame header
    localparam logic [7:0] HDR0_DEF = 8'hA5;
    localparam logic [7:0] HDR1_DEF = 8'h5A;

    localparam int PIX_W = 12;   // {B,G,R}, 4 bits each
    localparam int CNT_W = 15;   // pixel counter width, frames up to 32767 pixels

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    // Group b0,b1,b2 -> pixel A = {b0, b1[7:4]}, pixel B = {b1[3:0], b2}
    function automatic pix_t pix_first(input logic [7:0] b0, input logic [3:0] b1_hi);
        return {b0, b1_hi};
    endfunction

    function automatic pix_t pix_second(input logic [3:0] b1_lo, input logic [7:0] b2);
        return {b1_lo, b2};
    endfunction

endpackage

// File: rtl/pix_unpacker_if.sv
// ---------------------------------------------------------------------------
// pix_unpacker_if
//   Byte input and pixel output bundle of the unpacker.
//   slave  : unpacker side (consumes bytes, drives the pixel stream/status)
//   master : UART/frame-store side (drives bytes, observes pixels/status)
//   byte_valid/byte_data : one-cycle byte strobe from UART RX
//   rx_valid/rx_data     : pixel strobe + {B,G,R} toward the frame store
//   pix_sent             : pixels emitted in the current frame
//   frame_done/frame_err : sticky completion / abort flags
// ---------------------------------------------------------------------------
interface pix_unpacker_if import pix_unpacker_pkg::*; ();
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             rx_valid;
    pix_t             rx_data;
    logic [CNT_W-1:0] pix_sent;
    logic             frame_done;
    logic             frame_err;

    modport master (
        output byte_valid, byte_data,
        input  rx_valid, rx_data, pix_sent, frame_done, frame_err
    );

    modport slave (
        input  byte_valid, byte_data,
        output rx_valid, rx_data, pix_sent, frame_done, frame_err
    );
endinterface

// File: rtl/pix_unpacker_fifo2.sv
// ---------------------------------------------------------------------------
// pix_fifo2
//   Two-entry pixel FIFO between the byte unpacker and the pulse emitter.
//   Ports: clk_i, rst_ni (async, active low), push_i/data_i, pop_i, flush_i,
//          full_o, empty_o, head_o (oldest entry, valid when !empty_o).
//   A push while full is accepted only together with a pop; otherwise it is
//   dropped (the owner flags that case as an overrun). Pop on empty is ignored.
// ---------------------------------------------------------------------------
module pix_fifo2 import pix_unpacker_pkg::*; (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  pix_t data_i,
    input  logic pop_i,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    output pix_t head_o
);
    pix_t       mem_q [0:1];
    logic       rd_ptr_q;
    logic [1:0] cnt_q;

    logic do_pop, do_push, wr_ptr;

    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Write slot is rd+cnt mod 2; when full with a pop this is the slot being freed.
    assign wr_ptr  = rd_ptr_q ^ cnt_q[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) mem_q[wr_ptr] <= data_i;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/pix_unpacker.sv
// ---------------------------------------------------------------------------
// pix_unpacker
//   Front end of the image-load path. Hunts for the HDR0,HDR1 header in the
//   UART byte stream, unpacks each 3-byte group into two 12-bit pixels and
//   emits them as single-cycle pulses (always followed by a low cycle) to the
//   frame store while state_i == MODE_RX. Flags completion, timeout, overrun.
//   Ports: clk_i, rst_ni (async, active low), state_i (top-level mode),
//          bus (pix_unpacker_if.slave: byte in, pixel stream + status out).
// ---------------------------------------------------------------------------
module pix_unpacker import pix_unpacker_pkg::*; #(
    parameter int unsigned W           = 50,
    parameter int unsigned H           = 40,
    parameter logic [7:0]  HDR0        = HDR0_DEF,
    parameter logic [7:0]  HDR1        = HDR1_DEF,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [7:0]    state_i,
    pix_unpacker_if.slave bus
);
    localparam int unsigned NPIX  = W * H;
    localparam int          TMR_W = $clog2(TIMEOUT_CYC + 1);

    if (NPIX > 32767 || (NPIX % 2) != 0 || NPIX == 0 || TIMEOUT_CYC == 0) begin : g_bad_cfg
        $fatal(1, "pix_unpacker: W*H must be even, nonzero and <= 32767; TIMEOUT_CYC > 0");
    end

    state_e           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [7:0]       b0_q, b0_d;
    logic [3:0]       b1_lo_q, b1_lo_d;     // only the low nibble outlives b1
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] pix_in_q, pix_in_d;   // pixels unpacked so far
    logic             last_q, last_d;       // final pixel of the frame unpacked
    logic             rx_valid_q, rx_valid_d;
    pix_t             rx_data_q, rx_data_d;
    logic [CNT_W-1:0] pix_sent_q, pix_sent_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic push, emit, timeout, overrun;
    pix_t push_pix;
    logic fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    pix_t fifo_head;

    pix_fifo2 u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (push_pix),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_HDR0;
            phase_q    <= 2'd0;
            b0_q       <= '0;
            b1_lo_q    <= '0;
            tmr_q      <= '0;
            pix_in_q   <= '0;
            last_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            pix_sent_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            b0_q       <= b0_d;
            b1_lo_q    <= b1_lo_d;
            tmr_q      <= tmr_d;
            pix_in_q   <= pix_in_d;
            last_q     <= last_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            pix_sent_q <= pix_sent_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        b0_d       = b0_q;
        b1_lo_d    = b1_lo_q;
        tmr_d      = tmr_q;
        pix_in_d   = pix_in_q;
        last_d     = last_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        pix_sent_d = pix_sent_q;
        done_d     = done_q;
        err_d      = err_q;
        push       = 1'b0;
        push_pix   = '0;
        emit       = 1'b0;
        timeout    = 1'b0;
        overrun    = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        if (state_i != MODE_RX) begin
            // Out of receive mode: drop the frame; flags survive except in WAIT.
            state_d    = S_HDR0;
            phase_d    = 2'd0;
            tmr_d      = '0;
            pix_in_d   = '0;
            last_d     = 1'b0;
            pix_sent_d = '0;
            fifo_flush = 1'b1;
            if (state_i == MODE_WAIT) begin
                done_d = 1'b0;
                err_d  = 1'b0;
            end
        end else begin
            if (state_q == S_HDR1 || state_q == S_DATA) begin
                tmr_d   = bus.byte_valid ? '0 : tmr_q + TMR_W'(1);
                timeout = !bus.byte_valid && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
            end else begin
                tmr_d = '0;
            end

            unique case (state_q)
                S_HDR0: begin
                    if (bus.byte_valid && bus.byte_data == HDR0) state_d = S_HDR1;
                end
                S_HDR1: begin
                    if (bus.byte_valid) begin
                        if (bus.byte_data == HDR1) begin
                            state_d  = S_DATA;
                            phase_d  = 2'd0;
                            pix_in_d = '0;
                            last_d   = 1'b0;
                        end else if (bus.byte_data != HDR0) begin
                            // A repeated HDR0 keeps us armed for HDR1
                            state_d = S_HDR0;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.byte_valid && !last_q) begin
                        unique case (phase_q)
                            2'd0: begin
                                b0_d    = bus.byte_data;
                                phase_d = 2'd1;
                            end
                            2'd1: begin
                                b1_lo_d  = bus.byte_data[3:0];
                                push     = 1'b1;
                                push_pix = pix_first(b0_q, bus.byte_data[7:4]);
                                phase_d  = 2'd2;
                            end
                            default: begin
                                push     = 1'b1;
                                push_pix = pix_second(b1_lo_q, bus.byte_data);
                                phase_d  = 2'd0;
                            end
                        endcase
                    end

                    // Emit from the FIFO head, or straight from the incoming
                    // pixel when the FIFO is empty (1-cycle latency), but never
                    // on the cycle right after a pulse.
                    emit      = (push || !fifo_empty) && !rx_valid_q;
                    fifo_pop  = emit && !fifo_empty;
                    fifo_push = push && !(emit && fifo_empty);
                    overrun   = fifo_push && fifo_full && !fifo_pop;

                    if (push) begin
                        pix_in_d = pix_in_q + CNT_W'(1);
                        if (pix_in_q == CNT_W'(NPIX - 1)) last_d = 1'b1;
                    end
                    if (emit) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = fifo_empty ? push_pix : fifo_head;
                        pix_sent_d = pix_sent_q + CNT_W'(1);
                    end
                    if (last_q && fifo_empty) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
                S_DONE: done_d = 1'b1;
                default: begin
                    err_d      = 1'b1;
                    fifo_flush = 1'b1;
                end
            endcase

            // Abort wins over anything decided above: no pulse, no count.
            if (timeout || overrun) begin
                state_d    = S_ERR;
                err_d      = 1'b1;
                fifo_flush = 1'b1;
                fifo_push  = 1'b0;
                fifo_pop   = 1'b0;
                rx_valid_d = 1'b0;
                rx_data_d  = rx_data_q;
                pix_sent_d = pix_sent_q;
            end
        end
    end

    assign bus.rx_valid   = rx_valid_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.pix_sent   = pix_sent_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_pix_unpacker.sv
module tb_pix_unpacker;
    import pix_unpacker_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] mode;

    pix_unpacker_if bus ();

    pix_unpacker #(
        .W(4), .H(2), .HDR0(8'hA5), .HDR1(8'h5A), .TIMEOUT_CYC(50)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .state_i (mode),
        .bus     (bus)
    );

    int         total = 0;
    int         bad   = 0;
    int         pulses = 0;
    int         p0;
    logic       prev_rv = 1'b0;
    logic [11:0] sb [$];
    int         m_phase = 0;
    logic [7:0] m_b0, m_b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pixel monitor: every pulse must match the scoreboard head and follow a low cycle.
    always @(negedge clk) begin
        logic [11:0] exp_pix;
        if (bus.rx_valid === 1'b1) begin
            pulses++;
            chk("rx_valid_gap", 32'(prev_rv), 32'd0);
            exp_pix = (sb.size() != 0) ? sb.pop_front() : 12'hxxx;
            chk("rx_data", 32'(bus.rx_data), 32'(exp_pix));
        end
        prev_rv = bus.rx_valid;
    end

    // Drive one byte at a negedge; returns at the next negedge with the byte sampled.
    task automatic put(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.byte_valid = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic hdr();
        m_phase = 0;
        put(8'hA5);
        put(8'h5A);
    endtask

    // Data byte with expected pixels queued from the b0,b1,b2 packing rule.
    task automatic dat(input logic [7:0] b);
        case (m_phase)
            0: m_b0 = b;
            1: begin m_b1 = b; sb.push_back({m_b0, b[7:4]}); end
            default: sb.push_back({m_b1[3:0], b});
        endcase
        m_phase = (m_phase + 1) % 3;
        put(b);
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = MODE_WAIT;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rx_valid",   32'(bus.rx_valid),   32'd0);
        chk("rst_rx_data",    32'(bus.rx_data),    32'd0);
        chk("rst_pix_sent",   32'(bus.pix_sent),   32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_frame_err",  32'(bus.frame_err),  32'd0);
        rst_n = 1'b1;
        idle(2);

        // T1: spaced bytes, 1-cycle latency
        mode = MODE_RX;
        idle(1);
        m_phase = 0;
        put(8'hA5); idle(9);
        put(8'h5A); idle(9);
        dat(8'h12); idle(9);
        dat(8'h34);
        chk("t1_valid_a", 32'(bus.rx_valid), 32'd1);
        chk("t1_data_a",  32'(bus.rx_data),  32'h123);
        chk("t1_sent_a",  32'(bus.pix_sent), 32'd1);
        idle(9);
        dat(8'h56);
        chk("t1_valid_b", 32'(bus.rx_valid), 32'd1);
        chk("t1_data_b",  32'(bus.rx_data),  32'h456);
        chk("t1_sent_b",  32'(bus.pix_sent), 32'd2);
        idle(3);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // T2: full 4x2 frame on consecutive cycles, 13th byte ignored
        mode = MODE_WAIT;
        idle(2);
        chk("t2_cleared", 32'(bus.pix_sent), 32'd0);
        mode = MODE_RX;
        idle(1);
        p0 = pulses;
        hdr();
        for (int i = 0; i < 12; i++) dat(8'h21 + 8'(i * 17));
        put(8'hEE);
        idle(10);
        chk("t2_pulses",    32'(pulses - p0),      32'd8);
        chk("t2_done",      32'(bus.frame_done),   32'd1);
        chk("t2_no_err",    32'(bus.frame_err),    32'd0);
        chk("t2_pix_sent",  32'(bus.pix_sent),     32'd8);
        chk("t2_sb_empty",  32'(sb.size()),        32'd0);
        put(8'h77); put(8'h88);
        idle(4);
        chk("t2_after_sent",   32'(bus.pix_sent), 32'd8);
        chk("t2_after_pulses", 32'(pulses - p0),  32'd8);

        // T3: header resync through a bad byte and repeated A5
        mode = MODE_WAIT; idle(1);
        mode = MODE_RX;   idle(1);
        p0 = pulses;
        m_phase = 0;
        put(8'hA5); put(8'h00); put(8'hA5); put(8'hA5); put(8'h5A);
        idle(1);
        chk("t3_no_early_pulse", 32'(pulses - p0), 32'd0);
        dat(8'h12); dat(8'h34);
        chk("t3_valid", 32'(bus.rx_valid), 32'd1);
        chk("t3_data",  32'(bus.rx_data),  32'h123);
        idle(3);
        chk("t3_pulses",   32'(pulses - p0), 32'd1);
        chk("t3_sb_empty", 32'(sb.size()),   32'd0);

        // T4: timeout 50 cycles after the last byte
        mode = MODE_WAIT; idle(1);
        mode = MODE_RX;   idle(1);
        p0 = pulses;
        hdr();
        dat(8'h9A); dat(8'hBC); dat(8'hDE); dat(8'hF0); dat(8'h13);
        idle(49);
        chk("t4_pulses",    32'(pulses - p0),     32'd3);
        chk("t4_sb_empty",  32'(sb.size()),       32'd0);
        chk("t4_err_at_49", 32'(bus.frame_err),   32'd0);
        idle(1);
        chk("t4_err_at_50", 32'(bus.frame_err),   32'd1);
        put(8'h12); put(8'h34); put(8'h56);
        idle(4);
        chk("t4_no_more_pulses", 32'(pulses - p0),   32'd3);
        chk("t4_sent_held",      32'(bus.pix_sent),  32'd3);
        chk("t4_err_sticky",     32'(bus.frame_err), 32'd1);
        chk("t4_not_done",       32'(bus.frame_done), 32'd0);

        // T5: reset during a live pulse
        mode = MODE_WAIT; idle(1);
        chk("t5_err_cleared", 32'(bus.frame_err), 32'd0);
        mode = MODE_RX; idle(1);
        hdr();
        dat(8'h12); dat(8'h34);
        chk("t5_pulse_live", 32'(bus.rx_valid), 32'd1);
        bus.byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rx_valid_async", 32'(bus.rx_valid),   32'd0);
        chk("t5_rx_data",        32'(bus.rx_data),    32'd0);
        chk("t5_pix_sent",       32'(bus.pix_sent),   32'd0);
        chk("t5_done",           32'(bus.frame_done), 32'd0);
        chk("t5_err",            32'(bus.frame_err),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
        hdr();
        dat(8'h45); dat(8'h67); dat(8'h89);
        idle(4);
        chk("t5_new_frame_sent", 32'(bus.pix_sent), 32'd2);
        chk("t5_new_frame_sb",   32'(sb.size()),     32'd0);

        // T6: finish that frame, then leave and re-enter receive mode
        for (int i = 0; i < 9; i++) dat(8'hC3 ^ 8'(i * 29));
        idle(8);
        chk("t6_done",     32'(bus.frame_done), 32'd1);
        chk("t6_sent",     32'(bus.pix_sent),   32'd8);
        chk("t6_sb_empty", 32'(sb.size()),      32'd0);
        mode = MODE_DISP; idle(2);
        chk("t6_disp_done_kept", 32'(bus.frame_done), 32'd1);
        chk("t6_disp_sent_clr",  32'(bus.pix_sent),   32'd0);
        mode = MODE_WAIT; idle(1);
        chk("t6_wait_done_clr", 32'(bus.frame_done), 32'd0);
        chk("t6_wait_err_clr",  32'(bus.frame_err),  32'd0);
        mode = MODE_RX; idle(1);
        hdr();
        dat(8'hAB); dat(8'hCD); dat(8'hEF);
        idle(4);
        chk("t6_restart_sent", 32'(bus.pix_sent),   32'd2);
        chk("t6_restart_done", 32'(bus.frame_done), 32'd0);
        chk("t6_restart_sb",   32'(sb.size()),      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
